// File: rtl/seven_segment_capture.sv
// rtl/seven_segment_capture.sv - reconstructs digits from a multiplexed 4-digit seven-segment bus
//
// Purpose:
//   Watches an active-low, multiplexed 4-digit seven-segment bus and recovers the
//   hex digit and decimal point shown on each position. A digit is captured only
//   after the synchronized bus has held the same legal value for STABLE_CYCLES
//   consecutive samples. There is one capture per dwell.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   segment[7:0] [6:0]=CA..CG, [7]=DP, active-low, asynchronous to clk
//   anode[3:0]   digit enables, active-low, asynchronous to clk
//   digits[15:0] captured nibbles, [3:0]=digit0 .. [15:12]=digit3
//   dp[3:0]      captured decimal point per digit, 1 = lit
//   digit_valid  per digit, 1 = captured at least once since reset
//   bad_pattern  per digit, 1 = last capture was not a legal hex pattern
//   frame_done   one-cycle pulse when all four digits have been captured since the last pulse
module seven_segment_capture #(
  parameter int STABLE_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  segment,
  input  logic [3:0]  anode,
  output logic [15:0] digits,
  output logic [3:0]  dp,
  output logic [3:0]  digit_valid,
  output logic [3:0]  bad_pattern,
  output logic        frame_done
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;

  state_t        state;
  logic [CW-1:0] counter;
  logic [7:0]    seg_m, seg_s;
  logic [3:0]    an_m, an_s;
  logic [11:0]   prev;
  logic [3:0]    seen;

  logic [11:0]   sample;
  logic          an_legal;
  logic [3:0]    sel;
  logic          hit;
  logic [3:0]    nibble;
  logic [6:0]    pattern;

  // Two-flop synchronizer. Both stages preset to all-ones, so the bus looks blank
  // (illegal anode) right after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_m <= '1;
      seg_s <= '1;
      an_m  <= '1;
      an_s  <= '1;
    end else begin
      seg_m <= segment;
      seg_s <= seg_m;
      an_m  <= anode;
      an_s  <= an_m;
    end
  end

  assign sample  = {seg_s, an_s};
  assign pattern = ~seg_s[6:0];

  // An anode value is legal only when exactly one digit is enabled.
  // sel is the one-hot, active-high form of that digit.
  always_comb begin
    an_legal = 1'b1;
    sel      = 4'b0000;
    case (an_s)
      4'b1110: sel = 4'b0001;
      4'b1101: sel = 4'b0010;
      4'b1011: sel = 4'b0100;
      4'b0111: sel = 4'b1000;
      default: an_legal = 1'b0;
    endcase
  end

  // Decode the gfedcba pattern into a hex nibble.
  always_comb begin
    hit    = 1'b1;
    nibble = 4'h0;
    case (pattern)
      7'h3F: nibble = 4'h0;
      7'h06: nibble = 4'h1;
      7'h5B: nibble = 4'h2;
      7'h4F: nibble = 4'h3;
      7'h66: nibble = 4'h4;
      7'h6D: nibble = 4'h5;
      7'h7D: nibble = 4'h6;
      7'h07: nibble = 4'h7;
      7'h7F: nibble = 4'h8;
      7'h6F: nibble = 4'h9;
      7'h77: nibble = 4'hA;
      7'h7C: nibble = 4'hB;
      7'h39: nibble = 4'hC;
      7'h5E: nibble = 4'hD;
      7'h79: nibble = 4'hE;
      7'h71: nibble = 4'hF;
      default: hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      counter     <= '0;
      prev        <= '0;
      seen        <= 4'b0000;
      digits      <= 16'h0000;
      dp          <= 4'b0000;
      digit_valid <= 4'b0000;
      bad_pattern <= 4'b0000;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (an_legal) begin
            state   <= COUNT;
            counter <= CW'(1);
            prev    <= sample;
          end
        end
        COUNT: begin
          if (sample != prev || !an_legal) begin
            state   <= IDLE;
            counter <= '0;
          end else begin
            counter <= counter + CW'(1);
            if (counter == LAST) begin
              // This sample is the STABLE_CYCLES-th equal one: capture it.
              state <= HOLD;
              for (int i = 0; i < 4; i++) begin
                if (sel[i]) begin
                  if (hit) begin
                    digits[i*4 +: 4] <= nibble;
                  end
                  bad_pattern[i] <= ~hit;
                  dp[i]          <= ~seg_s[7];
                  digit_valid[i] <= 1'b1;
                end
              end
              if ((seen | sel) == 4'b1111) begin
                seen       <= 4'b0000;
                frame_done <= 1'b1;
              end else begin
                seen <= seen | sel;
              end
            end
          end
        end
        HOLD: begin
          // Counter is frozen here, so it never wraps during a long dwell.
          if (sample != prev) begin
            state   <= IDLE;
            counter <= '0;
          end
        end
        default: begin
          state   <= IDLE;
          counter <= '0;
        end
      endcase
    end
  end

endmodule
